// File: rtl/block_ram_banked_init_pkg.sv
// Shared types and helpers for the banked block RAM with fill engine.
package block_ram_banked_init_pkg;

  // Controller states: the fill engine owns the RAM in ST_FILL.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Read-during-write behaviour selectors.
  localparam string RDW_READ_FIRST  = "read_first";
  localparam string RDW_WRITE_FIRST = "write_first";

  // Address width for a given depth; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 32'd1) ? $unsigned($clog2(depth)) : 32'd1;
  endfunction

endpackage

// File: rtl/block_ram_banked_init_if.sv
// User-side bus of the banked block RAM: fill control, write port, read port.
interface block_ram_banked_init_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned ADDR_WIDTH = 4
) ();

  logic                            init_start;
  logic                            init_busy;
  logic [NUM_BANKS-1:0]            wr_en;
  logic [ADDR_WIDTH-1:0]           wr_addr;
  logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data;
  logic                            rd_en;
  logic [ADDR_WIDTH-1:0]           rd_addr;
  logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data;
  logic                            rd_valid;

  modport master (
    output init_start, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  init_busy, rd_data, rd_valid
  );

  modport slave (
    input  init_start, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output init_busy, rd_data, rd_valid
  );

endinterface

// File: rtl/block_ram_banked_init_bank.sv
// One simple-dual-port bank: unreset array, registered read, optional write-first bypass.
module block_ram_banked_init_bank
  import block_ram_banked_init_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           DEPTH      = 16,
  parameter int unsigned           ADDR_WIDTH = addr_width(DEPTH),
  parameter string                 RAM_STYLE  = "auto",
  parameter string                 RDW_MODE   = RDW_READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic                  roob_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam bit WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  // Reject unsupported configurations at elaboration time.
  if (!(RDW_MODE == RDW_READ_FIRST || RDW_MODE == RDW_WRITE_FIRST)) begin : g_bad_rdw
    $error("block_ram_banked_init_bank: unsupported RDW_MODE");
  end
  if (RAM_STYLE == "") begin : g_bad_style
    $error("block_ram_banked_init_bank: empty RAM_STYLE");
  end

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Write port; callers guarantee waddr_i is in range whenever we_i is set.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data selection: out-of-range, write-first bypass, or array word.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      if (roob_i) begin
        rdata_d = FILL_VALUE;
      end else if (WRITE_FIRST && we_i && (waddr_i == raddr_i)) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem_q[raddr_i];
      end
    end
  end

  // Read register; holds its value when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/block_ram_banked_init.sv
// Multi-bank SDP RAM with fill-on-reset/request engine and read-valid pipeline.
module block_ram_banked_init
  import block_ram_banked_init_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH      = 8,
  parameter int unsigned           DEPTH           = 16,
  parameter int unsigned           NUM_BANKS       = 2,
  parameter string                 RAM_STYLE       = "auto",
  parameter string                 OUTPUT_REGISTER = "false",
  parameter string                 RDW_MODE        = RDW_READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE      = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  block_ram_banked_init_if.slave bus
);

  localparam int unsigned    AW        = addr_width(DEPTH);
  localparam int unsigned    BUS_W     = NUM_BANKS * DATA_WIDTH;
  localparam logic [AW:0]    DEPTH_CMP = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam bit             OREG      = (OUTPUT_REGISTER == "true");

  if (!(OUTPUT_REGISTER == "true" || OUTPUT_REGISTER == "false")) begin : g_bad_oreg
    $error("block_ram_banked_init: OUTPUT_REGISTER must be \"true\" or \"false\"");
  end

  state_e            state_q;
  state_e            state_d;
  logic [AW-1:0]     fill_addr_q;
  logic [AW-1:0]     fill_addr_d;
  logic              busy_q;
  logic              valid1_q;

  logic [NUM_BANKS-1:0] bank_we;
  logic [AW-1:0]        bank_addr;
  logic [BUS_W-1:0]     bank_wdata;
  logic                 rd_issue;
  logic                 wr_in_range;
  logic                 rd_oob;
  logic [BUS_W-1:0]     stage1_data;

  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_CMP);
  assign rd_oob      = ({1'b0, bus.rd_addr} >= DEPTH_CMP);

  // State register, fill counter, busy flag and first read-valid stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      fill_addr_q <= '0;
      busy_q      <= 1'b1;
      valid1_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      busy_q      <= (state_d == ST_FILL);
      valid1_q    <= rd_issue;
    end
  end

  // Next state: sweep every address once, then wait for a refill request.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    case (state_q)
      ST_FILL: begin
        if (fill_addr_q == LAST_ADDR) begin
          state_d     = ST_IDLE;
          fill_addr_d = '0;
        end else begin
          fill_addr_d = fill_addr_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (bus.init_start) begin
          state_d = ST_FILL;
        end
      end
    endcase
  end

  // Write-port mux and read issue: the fill engine locks out all user traffic.
  always_comb begin
    bank_we    = '0;
    bank_addr  = bus.wr_addr;
    bank_wdata = bus.wr_data;
    rd_issue   = 1'b0;
    if (state_q == ST_FILL) begin
      bank_we    = '1;
      bank_addr  = fill_addr_q;
      bank_wdata = {NUM_BANKS{FILL_VALUE}};
    end else begin
      bank_we  = wr_in_range ? bus.wr_en : '0;
      rd_issue = bus.rd_en;
    end
  end

  // One bank per lane, all sharing the write and read addresses.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    block_ram_banked_init_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW),
      .RAM_STYLE  (RAM_STYLE),
      .RDW_MODE   (RDW_MODE),
      .FILL_VALUE (FILL_VALUE)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (bank_we[b]),
      .waddr_i (bank_addr),
      .wdata_i (bank_wdata[b*DATA_WIDTH +: DATA_WIDTH]),
      .re_i    (rd_issue),
      .raddr_i (bus.rd_addr),
      .roob_i  (rd_oob),
      .rdata_o (stage1_data[b*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Optional second stage: free-running so data and valid stay aligned.
  if (OREG) begin : g_oreg
    logic [BUS_W-1:0] data2_q;
    logic             valid2_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data2_q  <= '0;
        valid2_q <= 1'b0;
      end else begin
        data2_q  <= stage1_data;
        valid2_q <= valid1_q;
      end
    end

    assign bus.rd_data  = data2_q;
    assign bus.rd_valid = valid2_q;
  end else begin : g_no_oreg
    assign bus.rd_data  = stage1_data;
    assign bus.rd_valid = valid1_q;
  end

  assign bus.init_busy = busy_q;

endmodule

// File: tb/tb_block_ram_banked_init.sv
// Directed bench: four configurations driven by one shared stimulus set.
module tb_block_ram_banked_init;
  import block_ram_banked_init_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned NB = 2;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              init_start = 1'b0;
  logic [NB-1:0]     wr_en      = '0;
  logic [AW-1:0]     wr_addr    = '0;
  logic [NB*DW-1:0]  wr_data    = '0;
  logic              rd_en      = 1'b0;
  logic [AW-1:0]     rd_addr    = '0;

  int total = 0;
  int bad   = 0;

  // a: defaults, b: write_first, c: output register, d: DEPTH = 10
  block_ram_banked_init_if #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .ADDR_WIDTH(AW)) if_a ();
  block_ram_banked_init_if #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .ADDR_WIDTH(AW)) if_b ();
  block_ram_banked_init_if #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .ADDR_WIDTH(AW)) if_c ();
  block_ram_banked_init_if #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .ADDR_WIDTH(AW)) if_d ();

  assign {if_a.init_start, if_a.wr_en, if_a.wr_addr, if_a.wr_data, if_a.rd_en, if_a.rd_addr} =
         {init_start, wr_en, wr_addr, wr_data, rd_en, rd_addr};
  assign {if_b.init_start, if_b.wr_en, if_b.wr_addr, if_b.wr_data, if_b.rd_en, if_b.rd_addr} =
         {init_start, wr_en, wr_addr, wr_data, rd_en, rd_addr};
  assign {if_c.init_start, if_c.wr_en, if_c.wr_addr, if_c.wr_data, if_c.rd_en, if_c.rd_addr} =
         {init_start, wr_en, wr_addr, wr_data, rd_en, rd_addr};
  assign {if_d.init_start, if_d.wr_en, if_d.wr_addr, if_d.wr_data, if_d.rd_en, if_d.rd_addr} =
         {init_start, wr_en, wr_addr, wr_data, rd_en, rd_addr};

  block_ram_banked_init #(.DATA_WIDTH(DW), .DEPTH(16), .NUM_BANKS(NB)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a));
  block_ram_banked_init #(.DATA_WIDTH(DW), .DEPTH(16), .NUM_BANKS(NB), .RDW_MODE("write_first")) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b));
  block_ram_banked_init #(.DATA_WIDTH(DW), .DEPTH(16), .NUM_BANKS(NB), .OUTPUT_REGISTER("true")) u_dut_c (
    .clk(clk), .rst(rst), .bus(if_c));
  block_ram_banked_init #(.DATA_WIDTH(DW), .DEPTH(10), .NUM_BANKS(NB)) u_dut_d (
    .clk(clk), .rst(rst), .bus(if_d));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init_start = 1'b0;
    wr_en      = '0;
    rd_en      = 1'b0;
  endtask

  task automatic write_all(input logic [NB*DW-1:0] val);
    for (int a = 0; a < 16; a++) begin
      wr_en = '1; wr_addr = AW'(a); wr_data = val;
      cyc();
    end
    wr_en = '0;
  endtask

  task automatic test_reset();
    int len_a, len_c, len_d;
    idle_inputs();
    rst = 1'b1;
    repeat (2) cyc();
    total++; if (if_a.init_busy !== 1'b1) begin bad++; $display("FAIL reset_busy_a got=%b want=1", if_a.init_busy); end
    total++; if (if_a.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_a got=%b want=0", if_a.rd_valid); end
    total++; if (if_a.rd_data !== 16'h0000) begin bad++; $display("FAIL reset_data_a got=%h want=0000", if_a.rd_data); end
    total++; if (if_c.rd_data !== 16'h0000) begin bad++; $display("FAIL reset_data_c got=%h want=0000", if_c.rd_data); end
    total++; if (if_c.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_c got=%b want=0", if_c.rd_valid); end
    rst = 1'b0;
    len_a = 0; len_c = 0; len_d = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (len_a == 0 && if_a.init_busy === 1'b0) len_a = k;
      if (len_c == 0 && if_c.init_busy === 1'b0) len_c = k;
      if (len_d == 0 && if_d.init_busy === 1'b0) len_d = k;
    end
    total++; if (len_a != 16) begin bad++; $display("FAIL fill_len_a got=%0d want=16", len_a); end
    total++; if (len_c != 16) begin bad++; $display("FAIL fill_len_c got=%0d want=16", len_c); end
    total++; if (len_d != 10) begin bad++; $display("FAIL fill_len_d got=%0d want=10", len_d); end
  endtask

  task automatic test_fill_read();
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      cyc();
      total++; if (if_a.rd_valid !== 1'b1 || if_a.rd_data !== 16'hFFFF) begin
        bad++; $display("FAIL fill_rd_a addr=%0d got=%b/%h want=1/ffff", a, if_a.rd_valid, if_a.rd_data); end
      total++; if (if_b.rd_data !== 16'hFFFF) begin
        bad++; $display("FAIL fill_rd_b addr=%0d got=%h want=ffff", a, if_b.rd_data); end
    end
    rd_en = 1'b0;
    cyc();
    total++; if (if_a.rd_valid !== 1'b0 || if_a.rd_data !== 16'hFFFF) begin
      bad++; $display("FAIL rd_hold_a got=%b/%h want=0/ffff", if_a.rd_valid, if_a.rd_data); end
  endtask

  task automatic test_bank_we();
    wr_en = 2'b01; wr_addr = 4'd3; wr_data = 16'hAA55;
    cyc();
    wr_en = '0; rd_en = 1'b1; rd_addr = 4'd3;
    cyc();
    rd_en = 1'b0;
    total++; if (if_a.rd_data !== 16'hFF55) begin bad++; $display("FAIL bank_we_a got=%h want=ff55", if_a.rd_data); end
    total++; if (if_b.rd_data !== 16'hFF55) begin bad++; $display("FAIL bank_we_b got=%h want=ff55", if_b.rd_data); end
  endtask

  task automatic test_rdw();
    wr_en = 2'b11; wr_addr = 4'd5; wr_data = 16'h1122;
    cyc();
    wr_data = 16'h3344; rd_en = 1'b1; rd_addr = 4'd5;
    cyc();
    total++; if (if_a.rd_data !== 16'h1122) begin bad++; $display("FAIL rdw_read_first got=%h want=1122", if_a.rd_data); end
    total++; if (if_b.rd_data !== 16'h3344) begin bad++; $display("FAIL rdw_write_first got=%h want=3344", if_b.rd_data); end
    wr_en = '0;
    cyc();
    rd_en = 1'b0;
    total++; if (if_a.rd_data !== 16'h3344) begin bad++; $display("FAIL rdw_next_a got=%h want=3344", if_a.rd_data); end
    total++; if (if_b.rd_data !== 16'h3344) begin bad++; $display("FAIL rdw_next_b got=%h want=3344", if_b.rd_data); end
  endtask

  task automatic test_oreg();
    logic [NB*DW-1:0] exp [3];
    exp[0] = 16'h0102; exp[1] = 16'h0304; exp[2] = 16'h0506;
    for (int a = 0; a < 3; a++) begin
      wr_en = 2'b11; wr_addr = AW'(a); wr_data = exp[a];
      cyc();
    end
    wr_en = '0;
    rd_en = 1'b1; rd_addr = 4'd0;
    cyc();
    total++; if (if_c.rd_valid !== 1'b0) begin bad++; $display("FAIL oreg_lat1_valid got=%b want=0", if_c.rd_valid); end
    total++; if (if_a.rd_valid !== 1'b1 || if_a.rd_data !== 16'h0102) begin
      bad++; $display("FAIL noreg_lat1 got=%b/%h want=1/0102", if_a.rd_valid, if_a.rd_data); end
    for (int k = 0; k < 3; k++) begin
      if (k < 2) rd_addr = AW'(k + 1); else rd_en = 1'b0;
      cyc();
      total++; if (if_c.rd_valid !== 1'b1 || if_c.rd_data !== exp[k]) begin
        bad++; $display("FAIL oreg_b2b k=%0d got=%b/%h want=1/%h", k, if_c.rd_valid, if_c.rd_data, exp[k]); end
    end
    cyc();
    total++; if (if_c.rd_valid !== 1'b0 || if_c.rd_data !== 16'h0506) begin
      bad++; $display("FAIL oreg_idle got=%b/%h want=0/0506", if_c.rd_valid, if_c.rd_data); end
  endtask

  task automatic test_depth10();
    wr_en = 2'b11; wr_addr = 4'd12; wr_data = 16'h7777;
    cyc();
    wr_en = '0; rd_en = 1'b1; rd_addr = 4'd12;
    cyc();
    rd_en = 1'b0;
    total++; if (if_d.rd_valid !== 1'b1 || if_d.rd_data !== 16'hFFFF) begin
      bad++; $display("FAIL oob_rd_d got=%b/%h want=1/ffff", if_d.rd_valid, if_d.rd_data); end
    total++; if (if_a.rd_data !== 16'h7777) begin bad++; $display("FAIL inrange_12_a got=%h want=7777", if_a.rd_data); end
    rd_en = 1'b1; rd_addr = 4'd2;
    cyc();
    rd_en = 1'b0;
    total++; if (if_d.rd_data !== 16'h0506) begin bad++; $display("FAIL inrange_2_d got=%h want=0506", if_d.rd_data); end
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    wr_en = 2'b11; wr_addr = 4'd0; wr_data = 16'h1234; rd_en = 1'b1; rd_addr = 4'd0;
    while (if_a.init_busy === 1'b1 && n < 40) begin
      cyc();
      n++;
      total++; if (if_a.rd_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_in_fill n=%0d got=%b want=0", tag, n, if_a.rd_valid); end
    end
    idle_inputs();
    total++; if (n != 16) begin bad++; $display("FAIL %s_busy_len got=%0d want=16", tag, n); end
  endtask

  task automatic check_all_ff(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      cyc();
      total++; if (if_a.rd_data !== 16'hFFFF || if_b.rd_data !== 16'hFFFF) begin
        bad++; $display("FAIL %s_rd addr=%0d got=%h/%h want=ffff", tag, a, if_a.rd_data, if_b.rd_data); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_refill();
    write_all(16'h0000);
    rd_en = 1'b1; rd_addr = 4'd7;
    cyc();
    rd_en = 1'b0;
    total++; if (if_a.rd_data !== 16'h0000) begin bad++; $display("FAIL zero_fill_a got=%h want=0000", if_a.rd_data); end
    init_start = 1'b1;
    cyc();
    init_start = 1'b0;
    total++; if (if_a.init_busy !== 1'b1) begin bad++; $display("FAIL refill_busy got=%b want=1", if_a.init_busy); end
    count_busy("refill");
    check_all_ff("refill");
  endtask

  task automatic test_abort();
    write_all(16'h0000);
    init_start = 1'b1;
    cyc();
    init_start = 1'b0;
    repeat (7) cyc();
    rst = 1'b1;
    #1;
    total++; if (if_a.init_busy !== 1'b1 || if_a.rd_data !== 16'h0000) begin
      bad++; $display("FAIL abort_rst got=%b/%h want=1/0000", if_a.init_busy, if_a.rd_data); end
    cyc();
    rst = 1'b0;
    count_busy("abort");
    check_all_ff("abort");
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_bank_we();
    test_rdw();
    test_oreg();
    test_depth10();
    test_refill();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
